// File: rtl/replay_sched.sv
// replay_sched: schedules read requests toward the replay memory reader.
// On a rising edge of start_replay (seen in IDLE) it snapshots the packet
// count, loop count and inter-packet gap, then walks packet indices
// 0..mem_high_store-1 once per pass, inserting ipg_cycles idle cycles after
// every accepted request, until loop_cnt passes are done (0 = forever) or
// start_replay is dropped.
//
// Ports:
//   clk             sole clock, rising edge
//   reset, sw_rst   synchronous active-high resets (identical effect)
//   start_replay    level enable; rising edge starts a replay
//   mem_high_store  number of stored packets
//   loop_cnt        passes per replay, 0 = infinite
//   ipg_cycles      idle cycles after each accepted request
//   rd_req_vld/rd_req_ready/rd_addr   read request handshake and index
//   busy            replay in progress (ISSUE or GAP)
//   replay_done     replay finished normally (DONE)
//   loops_done, pkt_sent, cycle_count  statistics of current/last replay
module replay_sched #(
  parameter int QDR_ADDR_WIDTH  = 19,
  parameter int LOOP_WIDTH      = 16,
  parameter int GAP_WIDTH       = 16,
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sw_rst,
  input  logic                       start_replay,
  input  logic [QDR_ADDR_WIDTH-1:0]  mem_high_store,
  input  logic [LOOP_WIDTH-1:0]      loop_cnt,
  input  logic [GAP_WIDTH-1:0]       ipg_cycles,
  output logic                       rd_req_vld,
  input  logic                       rd_req_ready,
  output logic [QDR_ADDR_WIDTH-1:0]  rd_addr,
  output logic                       busy,
  output logic                       replay_done,
  output logic [LOOP_WIDTH-1:0]      loops_done,
  output logic [31:0]                pkt_sent,
  output logic [TIMESTAMP_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t                     state_reg;
  logic                       start_d_reg;
  // Set once start_replay has been seen low since the last reset, so a start
  // level that is still high coming out of reset is not mistaken for an edge.
  logic                       arm_reg;
  logic [QDR_ADDR_WIDTH-1:0]  mhs_reg;
  logic [LOOP_WIDTH-1:0]      loop_reg;
  logic [GAP_WIDTH-1:0]       ipg_reg;
  logic [GAP_WIDTH-1:0]       gap_cnt_reg;
  logic [QDR_ADDR_WIDTH-1:0]  rd_addr_reg;
  logic [LOOP_WIDTH-1:0]      loops_done_reg;
  logic [31:0]                pkt_sent_reg;
  logic [TIMESTAMP_WIDTH-1:0] cycle_count_reg;

  logic                       start_edge;
  logic                       handshake;
  logic                       end_of_pass;
  logic                       last_loop;
  logic [LOOP_WIDTH-1:0]      loops_inc;

  assign start_edge  = start_replay && !start_d_reg && arm_reg;
  assign handshake   = (state_reg == ISSUE) && rd_req_ready;
  assign end_of_pass = (rd_addr_reg == mhs_reg - QDR_ADDR_WIDTH'(1));
  assign loops_inc   = loops_done_reg + LOOP_WIDTH'(1);
  assign last_loop   = end_of_pass && (loop_reg != '0) && (loops_inc == loop_reg);

  always_ff @(posedge clk) begin
    if (reset || sw_rst) begin
      state_reg       <= IDLE;
      start_d_reg     <= 1'b0;
      arm_reg         <= 1'b0;
      mhs_reg         <= '0;
      loop_reg        <= '0;
      ipg_reg         <= '0;
      gap_cnt_reg     <= '0;
      rd_addr_reg     <= '0;
      loops_done_reg  <= '0;
      pkt_sent_reg    <= '0;
      cycle_count_reg <= '0;
    end else begin
      start_d_reg <= start_replay;
      if (!start_replay) begin
        arm_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            mhs_reg         <= mem_high_store;
            loop_reg        <= loop_cnt;
            ipg_reg         <= ipg_cycles;
            rd_addr_reg     <= '0;
            loops_done_reg  <= '0;
            pkt_sent_reg    <= '0;
            cycle_count_reg <= '0;
            state_reg       <= (mem_high_store == '0) ? DONE : ISSUE;
          end
        end

        ISSUE: begin
          cycle_count_reg <= cycle_count_reg + TIMESTAMP_WIDTH'(1);
          // Without a handshake the request (and its address) is held, even
          // when start_replay has dropped.
          if (handshake) begin
            pkt_sent_reg <= pkt_sent_reg + 32'd1;
            if (end_of_pass) begin
              rd_addr_reg <= '0;
              if (loops_done_reg != '1) begin
                loops_done_reg <= loops_inc;
              end
            end else begin
              rd_addr_reg <= rd_addr_reg + QDR_ADDR_WIDTH'(1);
            end

            if (!start_replay) begin
              state_reg <= IDLE;
            end else if (last_loop) begin
              state_reg <= DONE;
            end else if (ipg_reg != '0) begin
              gap_cnt_reg <= ipg_reg;
              state_reg   <= GAP;
            end
          end
        end

        GAP: begin
          cycle_count_reg <= cycle_count_reg + TIMESTAMP_WIDTH'(1);
          if (!start_replay) begin
            state_reg <= IDLE;
          end else if (gap_cnt_reg == GAP_WIDTH'(1)) begin
            state_reg <= ISSUE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
          end
        end

        DONE: begin
          if (!start_replay) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs come straight from registered state; no input reaches them
  // combinationally.
  assign rd_req_vld  = (state_reg == ISSUE);
  assign busy        = (state_reg == ISSUE) || (state_reg == GAP);
  assign replay_done = (state_reg == DONE);
  assign rd_addr     = rd_addr_reg;
  assign loops_done  = loops_done_reg;
  assign pkt_sent    = pkt_sent_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: doc/replay_sched.md
REPLAY_SCHED -- requirements
Module: replay_sched

Interface
REQ-001 Parameter QDR_ADDR_WIDTH, default 19: width of the replay memory address and of mem_high_store.
REQ-002 Parameter LOOP_WIDTH, default 16: width of loop_cnt and loops_done.
REQ-003 Parameter GAP_WIDTH, default 16: width of ipg_cycles.
REQ-004 Parameter TIMESTAMP_WIDTH, default 64: width of cycle_count.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sw_rst  in  1  software reset; synchronous, active-high, same effect as reset.
REQ-008 start_replay  in  1  level enable from control registers; its rising edge starts a replay.
REQ-009 mem_high_store  in  QDR_ADDR_WIDTH  number of stored packets; valid addresses are 0..mem_high_store-1.
REQ-010 loop_cnt  in  LOOP_WIDTH  passes over memory per replay; 0 means infinite.
REQ-011 ipg_cycles  in  GAP_WIDTH  idle cycles inserted after each accepted read request; 0 means back-to-back.
REQ-012 rd_req_vld  out  1  read request valid toward the replay memory reader.
REQ-013 rd_req_ready  in  1  reader accepts the request; handshake = rd_req_vld && rd_req_ready.
REQ-014 rd_addr  out  QDR_ADDR_WIDTH  packet index of the current request.
REQ-015 busy  out  1  high in ISSUE or GAP.
REQ-016 replay_done  out  1  high in DONE.
REQ-017 loops_done  out  LOOP_WIDTH  completed passes in the current or last replay.
REQ-018 pkt_sent  out  32  accepted requests in the current or last replay; wraps modulo 2^32.
REQ-019 cycle_count  out  TIMESTAMP_WIDTH  cycles spent busy in the current or last replay.

Function
REQ-020 FSM states: IDLE, ISSUE, GAP, DONE; registered state; all outputs decoded from registers (no combinational input-to-output paths).
REQ-021 Start edge = start_replay high while its 1-cycle-delayed copy is low; it is acted on only in IDLE.
REQ-022 On a start edge, the block latches mem_high_store, loop_cnt and ipg_cycles; it clears rd_addr, loops_done, pkt_sent and cycle_count; next state is ISSUE, or DONE if latched mem_high_store == 0.
REQ-023 rd_req_vld is 1 exactly in ISSUE; rd_addr is stable while rd_req_vld is high and not accepted.
REQ-024 On handshake: pkt_sent += 1; if rd_addr == latched mem_high_store-1 (end of pass), rd_addr <= 0 and loops_done += 1, else rd_addr += 1.
REQ-025 After a handshake, if the pass just ended and loop_cnt != 0 and loops_done+1 == loop_cnt, next state is DONE with no gap.
REQ-026 Otherwise, a handshake with ipg_cycles == 0 stays in ISSUE (a new request is possible every cycle); with ipg_cycles != 0 it enters GAP with gap counter = ipg_cycles.
REQ-027 In GAP, the gap counter decrements each cycle and the block returns to ISSUE on the cycle after the counter reads 1, so rd_req_vld is low for exactly ipg_cycles cycles.
REQ-028 cycle_count increments by 1 on every cycle in ISSUE or GAP and holds in IDLE and DONE; loops_done saturates at all-ones when loop_cnt == 0.
REQ-029 Abort: start_replay low in GAP -> IDLE next cycle.
REQ-030 Abort: start_replay low in ISSUE -> the outstanding request is held until its handshake, then IDLE; rd_req_vld is never withdrawn without a handshake.
REQ-031 On abort, counters hold their values and replay_done is not asserted.
REQ-032 In DONE, the block stays until start_replay is low, then goes to IDLE; a new start needs a fresh rising edge.
REQ-033 Input changes to mem_high_store, loop_cnt and ipg_cycles during a replay have no effect until the next start edge.

Reset
REQ-034 On reset or sw_rst (either takes priority over all other logic, any state): state IDLE; rd_req_vld, busy, replay_done 0; rd_addr, loops_done, pkt_sent, cycle_count 0; start-edge history 0.
REQ-035 Reset asserted mid-replay drops rd_req_vld on the next cycle regardless of rd_req_ready.

Verification
REQ-036 mem_high_store=4, loop_cnt=2, ipg=0, ready=1 -> rd_addr 0,1,2,3,0,1,2,3 on 8 consecutive cycles; then replay_done=1, pkt_sent=8, loops_done=2, cycle_count=8.
REQ-037 mem_high_store=3, loop_cnt=1, ipg=2 -> rd_req_vld pattern 1,0,0,1,0,0,1, then DONE; cycle_count=7.
REQ-038 ready toggled randomly -> rd_addr is stable while vld is high and not ready; sequence 0..N-1 with no skips or duplicates.
REQ-039 loop_cnt=0, mem_high_store=2, start held 10 cycles then deasserted in ISSUE with ready=0 -> vld is held until ready, then IDLE; replay_done stays 0.
REQ-040 mem_high_store=0 start -> DONE within 1 cycle, no request, pkt_sent=0.
REQ-041 sw_rst pulse mid-GAP -> all outputs 0 next cycle; start held high does not restart until it is deasserted and reasserted.
